// File: rtl/c_misalign.sv
// RV32C fetch realigner: turns aligned 32-bit fetch words into one instruction per cycle.
// Optional macro C_MISALIGN_HALF_TARGET_EN accepts branch targets on a halfword boundary.
module c_misalign #(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_for_branch,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic        stall_pc,
  output logic        pc_misaligned_o,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out
);

  localparam int unsigned HW = 16;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    UPPER   = 2'd1,
    SPAN    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [HW-1:0]  buf_hi_q, buf_hi_d;
  logic [31:0]    buf_pc_q, buf_pc_d;

  logic [HW-1:0]  lo_half, hi_half;
  logic           lo_cmp, hi_cmp;
  logic [31:0]    pc_plus2;

  assign lo_half  = inst_in[HW-1:0];
  assign hi_half  = inst_in[31:HW];
  assign lo_cmp   = (lo_half[1:0] != 2'b11);
  assign hi_cmp   = (hi_half[1:0] != 2'b11);
  assign pc_plus2 = pc_in + 32'd2;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ALIGNED;
      buf_hi_q <= '0;
      buf_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_hi_q <= buf_hi_d;
      buf_pc_q <= buf_pc_d;
    end
  end

  // Next-state and combinational issue logic
  always_comb begin
    state_d         = state_q;
    buf_hi_d        = buf_hi_q;
    buf_pc_d        = buf_pc_q;
    inst_out        = NOP;
    pc_out          = pc_in;
    stall_pc        = 1'b0;
    pc_misaligned_o = 1'b0;

    if (reset) begin
      state_d = ALIGNED;
    end else if (sel_for_branch) begin
      // Redirect discards any half-assembled instruction
      state_d  = ALIGNED;
      buf_hi_d = '0;
    end else begin
      unique case (state_q)
        ALIGNED: begin
`ifdef C_MISALIGN_HALF_TARGET_EN
          if (pc_in[1]) begin
            if (hi_cmp) begin
              inst_out        = {16'h0, hi_half};
              pc_misaligned_o = 1'b1;
            end else begin
              buf_hi_d = hi_half;
              buf_pc_d = pc_in;
              state_d  = SPAN;
            end
          end else
`endif
          begin
            if (!lo_cmp) begin
              inst_out = inst_in;
            end else begin
              inst_out = {16'h0, lo_half};
              if (hi_cmp) begin
                stall_pc = 1'b1;
                state_d  = UPPER;
              end else begin
                buf_hi_d = hi_half;
                buf_pc_d = pc_plus2;
                state_d  = SPAN;
              end
            end
          end
        end

        UPPER: begin
          inst_out        = {16'h0, hi_half};
          pc_out          = pc_plus2;
          pc_misaligned_o = 1'b1;
          state_d         = ALIGNED;
        end

        SPAN: begin
          inst_out        = {lo_half, buf_hi_q};
          pc_out          = buf_pc_q;
          pc_misaligned_o = 1'b1;
          if (hi_cmp) begin
            stall_pc = 1'b1;
            state_d  = UPPER;
          end else begin
            buf_hi_d = hi_half;
            buf_pc_d = pc_plus2;
          end
        end

        default: state_d = ALIGNED;
      endcase
    end
  end

endmodule

// File: tb/tb_c_misalign.sv
// Self-checking bench for c_misalign: directed vectors, then random fetch streams
// compared against a halfword-pointer reference model of the instruction stream.
module tb_c_misalign;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, sel_for_branch;
  logic [31:0] pc_in, inst_in;
  logic        stall_pc, pc_misaligned_o;
  logic [31:0] pc_out, inst_out;

  int checks   = 0;
  int failures = 0;
  logic prev_stall = 1'b0;

  logic [15:0] mem [0:2047];

  always #5 clk = ~clk;

  c_misalign dut (
    .clk            (clk),
    .reset          (reset),
    .sel_for_branch (sel_for_branch),
    .pc_in          (pc_in),
    .inst_in        (inst_in),
    .stall_pc       (stall_pc),
    .pc_misaligned_o(pc_misaligned_o),
    .pc_out         (pc_out),
    .inst_out       (inst_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs mid-cycle and check the combinational outputs
  task automatic apply_and_check(input logic r, input logic s, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic [31:0] e_inst,
                                 input logic [31:0] e_pc, input logic e_stall,
                                 input logic e_mis, input string tag);
    @(negedge clk);
    reset          = r;
    sel_for_branch = s;
    pc_in          = pc;
    inst_in        = inst;
    #2;
    check_eq({tag, "_inst"},  inst_out, e_inst);
    check_eq({tag, "_pc"},    pc_out,   e_pc);
    check_eq({tag, "_stall"}, {31'b0, stall_pc}, {31'b0, e_stall});
    check_eq({tag, "_mis"},   {31'b0, pc_misaligned_o}, {31'b0, e_mis});
    check_eq({tag, "_stall_pair"}, {31'b0, prev_stall & stall_pc}, 32'd0);
    prev_stall = stall_pc;
  endtask

  function automatic logic [15:0] hw(input logic [31:0] a);
    return mem[a[11:1]];
  endfunction

  function automatic logic is_c(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  function automatic logic [31:0] new_target();
    logic [31:0] t;
    t = $urandom();
    t[1:0] = 2'b00;
    if ($urandom_range(7) == 0) t = {28'hFFF_FFFF, t[3:2], 2'b00};
    return t;
  endfunction

  initial begin
    logic        r, s, es, em, redirect;
    logic [31:0] pc, pending, word, ei, ep, len;
    logic [15:0] h;

    reset = 1'b1; sel_for_branch = 1'b0; pc_in = '0; inst_in = '0;

    // Directed sequence from the documented examples
    apply_and_check(1, 0, 32'h0,  32'h1234_5678, NOP, 32'h0, 0, 0, "rst");
    apply_and_check(0, 0, 32'h0,  32'h006f0089, 32'h0000_0089, 32'h0,  0, 0, "d0");
    apply_and_check(0, 0, 32'h4,  32'h20230040, 32'h0040_006f, 32'h2,  0, 1, "d1");
    apply_and_check(0, 0, 32'h8,  32'hc1040095, 32'h0095_2023, 32'h6,  1, 1, "d2");
    apply_and_check(0, 0, 32'h8,  32'hc1040095, 32'h0000_c104, 32'hA,  0, 1, "d3");
    apply_and_check(0, 0, 32'hC,  32'h00001101, 32'h0000_1101, 32'hC,  1, 0, "d4");
    apply_and_check(0, 1, 32'hC,  32'h00001101, NOP,           32'hC,  0, 0, "d5_br");
    apply_and_check(0, 0, 32'h10, 32'h0863c104, 32'h0000_c104, 32'h10, 0, 0, "d6");
    apply_and_check(0, 0, 32'h14, 32'h41040094, 32'h0094_0863, 32'h12, 1, 1, "d7");
    apply_and_check(0, 0, 32'h14, 32'h41040094, 32'h0000_4104, 32'h16, 0, 1, "d8");
    apply_and_check(0, 0, 32'h20, 32'h00000013, 32'h0000_0013, 32'h20, 0, 0, "d9");
    // Branch while spanning must drop the buffered half
    apply_and_check(0, 0, 32'h30, 32'h0863c104, 32'h0000_c104, 32'h30, 0, 0, "d10");
    apply_and_check(0, 1, 32'h34, 32'h41040094, NOP,           32'h34, 0, 0, "d11_br");
    apply_and_check(0, 0, 32'h80, 32'h00000013, 32'h0000_0013, 32'h80, 0, 0, "d12");
    // Reset beats a simultaneous branch
    apply_and_check(0, 0, 32'h84, 32'h0863c104, 32'h0000_c104, 32'h84, 0, 0, "d13");
    apply_and_check(1, 1, 32'h88, 32'h41040094, NOP,           32'h88, 0, 0, "d14_rb");
    apply_and_check(0, 0, 32'h90, 32'hffff0013, 32'hffff_0013, 32'h90, 0, 0, "d15");
    // Address wrap across the top of memory
    apply_and_check(0, 0, 32'hFFFF_FFFC, 32'h0863c104, 32'h0000_c104, 32'hFFFF_FFFC, 0, 0, "w0");
    apply_and_check(0, 0, 32'h0, 32'h00000013, 32'h0013_0863, 32'hFFFF_FFFE, 1, 1, "w1");
    apply_and_check(0, 0, 32'h0, 32'h00000013, 32'h0000_0000, 32'h2, 0, 1, "w2");

    // Random instruction memory, roughly half compressed halfwords
    for (int i = 0; i < 2048; i++) begin
      h = 16'($urandom());
      if ($urandom_range(1) == 0) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
      mem[i] = h;
    end

    // Model: pointer to the next instruction's halfword address in the stream
    pc = 32'h0; pending = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      r = (n == 0) || ($urandom_range(63) == 0);
      s = !r && ($urandom_range(15) == 0);
      word = {hw(pc + 32'd2), hw(pc)};
      if (r || s) begin
        ei = NOP; ep = pc; es = 1'b0; em = 1'b0; redirect = 1'b1;
      end else begin
        h = hw(pending);
        if (is_c(h)) begin
          ei = {16'h0, h}; len = 32'd2;
        end else begin
          ei = {hw(pending + 32'd2), h}; len = 32'd4;
        end
        ep = pending;
        em = (pending != pc);
        pending = pending + len;
        es = (pending == pc + 32'd2) && is_c(hw(pc + 32'd2));
        redirect = 1'b0;
      end
      apply_and_check(r, s, pc, word, ei, ep, es, em, "rnd");
      if (redirect) begin
        pc = new_target();
        pending = pc;
      end else if (!es) begin
        pc = pc + 32'd4;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c_misalign.md
Name: c_misalign

Overview:
- Fetch-side realigner for RISC-V RV32C, placed between instruction memory and decode.
- Takes one 32-bit aligned fetch word per cycle and emits one instruction per cycle:
  - a 16-bit compressed instruction, zero-extended; or
  - a 32-bit instruction, which may straddle two fetch words.
- Tells the PC logic when to hold the fetch address, and flags halfword-offset instructions.

Parameters:
- NOP, 32'h0000_0013, bubble instruction emitted when no valid instruction is available.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- sel_for_branch  input  1  branch/jump redirect taken this cycle; flushes realign state
- pc_in  input  32  address of the fetch word currently on inst_in
- inst_in  input  32  fetched word; low half at pc_in, high half at pc_in+2
- stall_pc  output  1  hold fetch PC next cycle (current word still holds an unissued halfword)
- pc_misaligned_o  output  1  issued instruction starts at pc_in+2 or earlier, not at pc_in
- pc_out  output  32  address of the instruction on inst_out
- inst_out  output  32  issued instruction; compressed ones zero-extended in [15:0]

Behaviour:
- A halfword h is compressed iff h[1:0] != 2'b11.
- Outputs are combinational from state and inputs. State registers:
  - fsm in {ALIGNED, UPPER, SPAN}
  - buf_hi[15:0]: saved upper halfword
  - buf_pc[31:0]: address of the saved halfword
- Reset (synchronous): fsm=ALIGNED, buf_hi=0, buf_pc=0. While reset=1: inst_out=NOP, pc_out=pc_in, stall_pc=0, pc_misaligned_o=0.
- ALIGNED, pc_in[1]=0:
  - Low half not compressed: inst_out=inst_in, pc_out=pc_in; stay ALIGNED.
  - Low compressed and upper compressed: inst_out={16'h0, inst_in[15:0]}, pc_out=pc_in, stall_pc=1; next UPPER.
  - Low compressed and upper not compressed: inst_out={16'h0, inst_in[15:0]}, pc_out=pc_in, stall_pc=0; buf_hi<=inst_in[31:16], buf_pc<=pc_in+2; next SPAN.
- UPPER (same word re-presented): inst_out={16'h0, inst_in[31:16]}, pc_out=pc_in+2, pc_misaligned_o=1, stall_pc=0; next ALIGNED.
- SPAN:
  - inst_out={inst_in[15:0], buf_hi}, pc_out=buf_pc, pc_misaligned_o=1.
  - If inst_in[31:16] is compressed: stall_pc=1, next UPPER.
  - Otherwise: buf_hi<=inst_in[31:16], buf_pc<=pc_in+2, stall_pc=0, stay SPAN.
- pc_misaligned_o=0 in every case not listed above.
- sel_for_branch=1 (takes priority over the FSM rules, but not over reset): inst_out=NOP, pc_out=pc_in, stall_pc=0, pc_misaligned_o=0; next ALIGNED, buf_hi cleared. Any half-assembled instruction is discarded.
- Simultaneous reset and sel_for_branch: reset wins.
- stall_pc is high for exactly one cycle per double-compressed word, and is never high in two consecutive cycles.
- Address arithmetic is modulo 2^32; pc_in+2 wraps at 32'hFFFF_FFFE.

Optional Feature:
- Macro C_MISALIGN_HALF_TARGET_EN, which enables branch targets on a halfword boundary.
- Defined, in ALIGNED with pc_in[1]=1 (first fetch after a redirect to a halfword target):
  - Upper compressed: inst_out={16'h0, inst_in[31:16]}, pc_out=pc_in, pc_misaligned_o=1; stay ALIGNED.
  - Upper not compressed: inst_out=NOP, buf_hi<=inst_in[31:16], buf_pc<=pc_in; next SPAN.
- Not defined: pc_in[1] is ignored and treated as 0.

Test Plan:
- Reset, then pc_in=0x0, inst_in=0x006f0089 -> inst_out=0x00000089, pc_out=0x0, stall_pc=0; next cycle pc_in=0x4, inst_in=0x20230040 -> inst_out=0x0040006f, pc_out=0x2, pc_misaligned_o=1.
- Continue pc_in=0x8, inst_in=0xc1040095 -> inst_out=0x00952023, pc_out=0x6, stall_pc=1; same word next cycle -> inst_out=0x0000c104, pc_out=0xA, stall_pc=0, fsm ALIGNED.
- pc_in=0xC, inst_in=0x00001101 -> inst_out=0x00001101, stall_pc=1; assert sel_for_branch next cycle -> inst_out=0x00000013, stall_pc=0, state flushed to ALIGNED.
- pc_in=0x10, inst_in=0x0863c104 -> inst_out=0x0000c104, stall_pc=0; pc_in=0x14, inst_in=0x41040094 -> inst_out=0x00940863, pc_out=0x12, stall_pc=1; next cycle -> inst_out=0x00004104, pc_out=0x16.
- Aligned 32-bit stream: pc_in=0x20, inst_in=0x00000013 -> passthrough, pc_out=0x20, stall_pc=0, pc_misaligned_o=0.
- With C_MISALIGN_HALF_TARGET_EN: after redirect, pc_in=0x22, inst_in=0x006f0089 -> inst_out=NOP; next word 0x20230040 -> inst_out=0x0040006f, pc_out=0x22.
